// File: rtl/ak6502_bus_pkg.sv
// ak6502 bus controller shared types: FSM states, address regions,
// timeout constant and region decode.
package ak6502_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    RGN_RAM,
    RGN_IO,
    RGN_ROM
  } region_t;

  localparam logic [7:0] TIMEOUT = 8'd255;

  function automatic region_t decode(
    input logic [15:0] addr,
    input logic [15:0] io_base,
    input logic [15:0] rom_base
  );
    if (addr >= rom_base) return RGN_ROM;
    if (addr >= io_base)  return RGN_IO;
    return RGN_RAM;
  endfunction

endpackage

// File: rtl/ak6502_bus_ctrl.sv
// ak6502 CPU-to-memory bus controller with region decode and timeout.
// Define AK6502_WAIT_STATE_EN to enable per-region wait states.
module ak6502_bus_ctrl
  import ak6502_bus_pkg::*;
#(
  parameter logic [15:0] IO_BASE  = 16'hD000,
  parameter logic [15:0] ROM_BASE = 16'hE000,
  parameter logic [3:0]  RAM_WS   = 4'd0,
  parameter logic [3:0]  IO_WS    = 4'd2,
  parameter logic [3:0]  ROM_WS   = 4'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic        cpu_ph2,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        cpu_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        rom_wr_err,
  output logic        bus_err
);

  state_t     state;
  logic [7:0] tmo_cnt;
  region_t    rgn;

  assign rgn = decode(cpu_addr, IO_BASE, ROM_BASE);

`ifdef AK6502_WAIT_STATE_EN
  region_t    region_q;
  logic [3:0] wait_cnt;
  logic [3:0] ws;

  always_comb begin
    ws = RAM_WS;
    unique case (region_q)
      RGN_IO:  ws = IO_WS;
      RGN_ROM: ws = ROM_WS;
      default: ws = RAM_WS;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      region_q <= RGN_RAM;
      wait_cnt <= 4'd0;
    end else begin
      if (state == IDLE && cpu_ph2)
        region_q <= rgn;
      if (state == REQ && mem_ack)
        wait_cnt <= ws;
      else if (state == WAIT)
        wait_cnt <= wait_cnt - 4'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tmo_cnt    <= 8'd0;
      cpu_ready  <= 1'b1;
      cpu_din    <= 8'h00;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 16'h0000;
      mem_wdata  <= 8'h00;
      rom_wr_err <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      rom_wr_err <= 1'b0;
      bus_err    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cpu_ph2) begin
            mem_addr  <= cpu_addr;
            mem_we    <= ~cpu_rw;
            mem_wdata <= cpu_dout;
            cpu_ready <= 1'b0;
            tmo_cnt   <= 8'd0;
            // ROM writes are dropped without touching the memory bus
            if (!cpu_rw && rgn == RGN_ROM) begin
              rom_wr_err <= 1'b1;
              state      <= DONE;
            end else begin
              mem_req <= 1'b1;
              state   <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we)
              cpu_din <= mem_rdata;
`ifdef AK6502_WAIT_STATE_EN
            state <= (ws == 4'd0) ? DONE : WAIT;
`else
            state <= DONE;
`endif
          end else if (tmo_cnt == TIMEOUT - 8'd1) begin
            mem_req <= 1'b0;
            cpu_din <= 8'hFF;
            bus_err <= 1'b1;
            state   <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        WAIT: begin
`ifdef AK6502_WAIT_STATE_EN
          if (wait_cnt == 4'd1)
            state <= DONE;
`else
          state <= IDLE;
`endif
        end
        DONE: begin
          cpu_ready <= 1'b1;
          tmo_cnt   <= 8'd0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
